// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: FSM states, request ops
// and the wait-state limit.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_LD   = 2'd1,
    OP_ST   = 2'd2
  } op_t;

  // Read and write together is not an operation; it becomes OP_NONE.
  function automatic op_t decode_op(input logic rd, input logic wr);
    op_t op;
    op = OP_NONE;
    if (rd && !wr) op = OP_LD;
    if (wr && !rd) op = OP_ST;
    return op;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised single-port RAM: 32-bit words, synchronous write,
// registered read-first output.
module dmem_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multicycle load/store responder with WAIT_CYCLES wait states and a
// one-cycle mem_ready strobe. Define DMEM_BOUNDS_CHECK_EN to flag and
// suppress misaligned / out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAdress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam logic [3:0] LP_WAIT = (WAIT_CYCLES > WAIT_MAX) ? 4'(WAIT_MAX) : 4'(WAIT_CYCLES);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  op_t               r_op;
  logic              r_err;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;

  logic              w_accept;
  logic              w_bad_addr;
  logic              w_fire;
  logic              w_we;
  logic [ADDR_W-1:0] w_idx_in;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_rdata;

  assign w_idx_in = dAdress[ADDR_W+1:2];
  assign w_accept = (r_state == ST_IDLE) && (MemRead || MemWrite);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_bad_addr = (dAdress[1:0] != 2'b00) || (|dAdress[31:ADDR_W+2]);
`else
  logic w_unused;
  assign w_bad_addr = 1'b0;
  assign w_unused   = ^{dAdress[1:0], dAdress[31:ADDR_W+2]};
`endif

  // The RAM reads every cycle; in IDLE it looks at the live address so a
  // zero-wait load still has its word ready on the edge entering RESP.
  assign w_ram_addr = (r_state == ST_IDLE) ? w_idx_in : r_idx;
  assign w_fire     = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_we       = w_fire && (r_op == OP_ST) && !r_err;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_op      <= OP_NONE;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      dReadData <= 32'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= decode_op(MemRead, MemWrite);
            r_err   <= (MemRead && MemWrite) || w_bad_addr;
            r_idx   <= w_idx_in;
            r_wdata <= dWriteData;
            r_cnt   <= LP_WAIT;
            r_state <= ST_WAIT;
          end
        end
        // WAIT always lasts at least one cycle, giving WAIT_CYCLES+1 latency.
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state   <= ST_RESP;
            mem_ready <= 1'b1;
            mem_err   <= r_err;
            if ((r_op == OP_LD) && !r_err) dReadData <= w_ram_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          mem_err <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
